// File: rtl/adler32_arbiter_pkg.sv
// Shared definitions for the adler32 arbiter: FSM state encoding.
package adler32_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_WAIT_CK = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/adler_rr_pick.sv
// Round-robin picker: finds the first set request starting at ptr and
// wrapping at NREQ. Purely combinational.
module adler_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] pos;

  // Scan from the farthest offset back to ptr so the nearest request in rotation order wins.
  always_comb begin
    any = |req;
    idx = '0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = IDW'((int'(ptr) + k) % NREQ);
      idx = req[pos] ? pos : idx;
    end
  end

endmodule

// File: rtl/adler32_arbiter.sv
// adler32_arbiter: shares one adler32 core among NREQ byte-stream requesters.
// A whole message is granted at a time; bytes are forwarded combinationally
// to the core and the checksum is returned as a one-cycle response.
// Optional feature macro: ADLER_ARB_TIMEOUT_EN (abort WAIT_CK after TIMEOUT cycles).
module adler32_arbiter
  import adler32_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
`ifdef ADLER_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_checksum,
  output logic              resp_error,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              core_data_valid,
  output logic [7:0]        core_data,
  output logic              core_last_data,
  input  logic              core_checksum_valid,
  input  logic [31:0]       core_checksum
);

  arb_state_e       state_r;
  logic [IDW-1:0]   rr_ptr_r;
  logic [IDW-1:0]   grant_r;
  logic [NREQ-1:0]  resp_valid_r;
  logic [31:0]      resp_checksum_r;
  logic             busy_r;
  logic             pick_any_s;
  logic [IDW-1:0]   pick_idx_s;
  logic             fwd_valid_s;
  logic             fwd_last_s;
  logic [7:0]       fwd_data_s;
  logic [IDW-1:0]   rr_next_s;
`ifdef ADLER_ARB_TIMEOUT_EN
  logic             resp_error_r;
  logic [9:0]       wait_cnt_r;
`endif

  adler_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_r),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

  assign fwd_valid_s = req_valid[grant_r];
  assign fwd_last_s  = req_last[grant_r];
  assign rr_next_s   = (grant_r == IDW'(NREQ - 1)) ? '0 : grant_r + IDW'(1);

  // Select the granted requester's byte lane.
  always_comb begin
    fwd_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      fwd_data_s = (grant_r == IDW'(i)) ? req_data[8*i +: 8] : fwd_data_s;
    end
  end

  // Zero-latency forwarding of the grantee's stream to the core while streaming.
  always_comb begin
    req_ready       = '0;
    core_data_valid = 1'b0;
    core_data       = 8'd0;
    core_last_data  = 1'b0;
    if (state_r == ST_STREAM) begin
      req_ready[grant_r] = 1'b1;
      core_data_valid    = fwd_valid_s;
      core_data          = fwd_data_s;
      core_last_data     = fwd_valid_s & fwd_last_s;
    end else begin
      req_ready       = '0;
      core_data_valid = 1'b0;
      core_data       = 8'd0;
      core_last_data  = 1'b0;
    end
  end

  // Arbitration FSM with grant, round-robin pointer, checksum and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      rr_ptr_r        <= '0;
      grant_r         <= '0;
      resp_valid_r    <= '0;
      resp_checksum_r <= 32'd0;
      busy_r          <= 1'b0;
`ifdef ADLER_ARB_TIMEOUT_EN
      resp_error_r    <= 1'b0;
      wait_cnt_r      <= 10'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            grant_r <= pick_idx_s;
            busy_r  <= 1'b1;
            state_r <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (fwd_valid_s && fwd_last_s) begin
            // A checksum arriving on the last-byte cycle belongs to this message.
            if (core_checksum_valid) begin
              resp_valid_r[grant_r] <= 1'b1;
              resp_checksum_r       <= core_checksum;
              state_r               <= ST_RESP;
            end else begin
`ifdef ADLER_ARB_TIMEOUT_EN
              wait_cnt_r <= 10'd0;
`endif
              state_r <= ST_WAIT_CK;
            end
          end
        end
        ST_WAIT_CK: begin
          if (core_checksum_valid) begin
            resp_valid_r[grant_r] <= 1'b1;
            resp_checksum_r       <= core_checksum;
            state_r               <= ST_RESP;
          end
`ifdef ADLER_ARB_TIMEOUT_EN
          else if (wait_cnt_r == 10'(TIMEOUT - 1)) begin
            resp_valid_r[grant_r] <= 1'b1;
            resp_checksum_r       <= 32'd0;
            resp_error_r          <= 1'b1;
            state_r               <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 10'd1;
          end
`endif
        end
        ST_RESP: begin
          resp_valid_r <= '0;
`ifdef ADLER_ARB_TIMEOUT_EN
          resp_error_r <= 1'b0;
`endif
          rr_ptr_r     <= rr_next_s;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid    = resp_valid_r;
  assign resp_checksum = resp_checksum_r;
  assign busy          = busy_r;
  assign grant_id      = grant_r;
`ifdef ADLER_ARB_TIMEOUT_EN
  assign resp_error    = resp_error_r;
`else
  assign resp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_adler32_arbiter.sv
// Self-checking bench for adler32_arbiter: directed scenarios plus random
// message batches, checked against a message-level round-robin model and a
// whole-message adler32 reference. Includes a behavioural adler32 core.
module tb_adler32_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [31:0]       resp_checksum;
  logic              resp_error;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              core_data_valid;
  logic [7:0]        core_data;
  logic              core_last_data;
  logic              core_checksum_valid;
  logic [31:0]       core_checksum;

  always #5 clk = ~clk;

  adler32_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_last            (req_last),
    .req_ready           (req_ready),
    .resp_valid          (resp_valid),
    .resp_checksum       (resp_checksum),
    .resp_error          (resp_error),
    .busy                (busy),
    .grant_id            (grant_id),
    .core_data_valid     (core_data_valid),
    .core_data           (core_data),
    .core_last_data      (core_last_data),
    .core_checksum_valid (core_checksum_valid),
    .core_checksum       (core_checksum)
  );

  // ---------------- behavioural adler32 core ----------------
  logic [15:0] ca, cb;
  logic [31:0] na_s, nb_s, res_r, cs_r;
  logic        ccv_r;
  int          pend;
  int          core_lat;
  bit          zl;
  bit          spur;

  // Next running sums if the current byte is absorbed.
  always_comb begin
    na_s = (32'(ca) + 32'(core_data)) % 32'd65521;
    nb_s = (32'(cb) + na_s) % 32'd65521;
  end

  // Core outputs: zero-latency mode answers on the last-byte cycle; spur injects a stray pulse.
  always_comb begin
    core_checksum_valid = spur | (zl ? (core_data_valid & core_last_data) : ccv_r);
    core_checksum       = spur ? 32'hDEADBEEF : (zl ? {nb_s[15:0], na_s[15:0]} : cs_r);
  end

  // Core state: accumulate bytes, answer core_lat cycles after the last byte.
  always @(posedge clk) begin
    if (!rst_n) begin
      ca <= 16'd1; cb <= 16'd0; pend <= 0; ccv_r <= 1'b0; cs_r <= 32'd0; res_r <= 32'd0;
    end else begin
      ccv_r <= 1'b0;
      if (pend == 1) begin
        ccv_r <= 1'b1; cs_r <= res_r; pend <= 0;
      end else if (pend > 1) begin
        pend <= pend - 1;
      end
      if (core_data_valid) begin
        if (core_last_data) begin
          ca <= 16'd1; cb <= 16'd0;
          res_r <= {nb_s[15:0], na_s[15:0]};
          pend <= zl ? 0 : core_lat;
        end else begin
          ca <= na_s[15:0]; cb <= nb_s[15:0];
        end
      end
    end
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  bq [NREQ][$];
  bit          lq [NREQ][$];
  logic [31:0] ck_pend [NREQ][$];
  int          cnt_pend [NREQ];
  bit          mid [NREQ];
  int          exp_id [$];
  logic [31:0] exp_ck [$];
  int          got_id [$];
  logic [31:0] got_ck [$];
  logic [NREQ-1:0] acc;
  int cyc, last_resp_cyc, last_id, model_ptr, gap_pct;
  logic [31:0] last_resp_ck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [31:0] adler(input logic [7:0] b[$]);
    int unsigned a = 1;
    int unsigned s = 0;
    foreach (b[k]) begin
      a = (a + b[k]) % 65521;
      s = (s + a) % 65521;
    end
    return {s[15:0], a[15:0]};
  endfunction

  task automatic add_msg(input int r, input logic [7:0] b[$]);
    foreach (b[k]) begin
      bq[r].push_back(b[k]);
      lq[r].push_back(k == b.size() - 1);
    end
    ck_pend[r].push_back(adler(b));
    cnt_pend[r]++;
  endtask

  task automatic add_rand_msg(input int r, input int len);
    logic [7:0] b[$];
    for (int k = 0; k < len; k++) b.push_back(8'($urandom));
    add_msg(r, b);
  endtask

  // Message-level round robin: serve the first pending requester from the pointer, then move past it.
  task automatic commit();
    bit any;
    int j;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < NREQ && !any; k++) begin
        j = (model_ptr + k) % NREQ;
        if (cnt_pend[j] > 0) begin
          any = 1'b1;
          exp_id.push_back(j);
          exp_ck.push_back(ck_pend[j].pop_front());
          cnt_pend[j]--;
          model_ptr = (j + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic step();
    int g;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && bq[i].size() > 0) begin
        mid[i] = !lq[i][0];
        void'(bq[i].pop_front());
        void'(lq[i].pop_front());
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bq[i].size() > 0) begin
        req_valid[i]      = mid[i] ? ($urandom_range(99) >= gap_pct) : 1'b1;
        req_data[8*i +: 8] = bq[i][0];
        req_last[i]       = lq[i][0];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]       = 1'($urandom);
      end
    end
    #1;
    acc = req_valid & req_ready & {NREQ{rst_n}};
    if (rst_n) chk("core_valid", core_data_valid, |acc);
    if (acc != '0) begin
      if (exp_id.size() > 0) begin
        g = exp_id[0];
        chk("accept_owner", acc, onehot(g));
        chk("core_data", core_data, bq[g][0]);
        chk("core_last", core_last_data, lq[g][0]);
      end else begin
        chk("accept_unexpected", acc, '0);
      end
    end
    if (resp_valid != '0) begin
      if (exp_id.size() == 0) begin
        chk("resp_unexpected", resp_valid, '0);
      end else begin
        chk("resp_owner", resp_valid, onehot(exp_id[0]));
        chk("resp_checksum", resp_checksum, exp_ck[0]);
        chk("resp_error", resp_error, 1'b0);
        chk("busy_in_resp", busy, 1'b1);
        for (int i = NREQ - 1; i >= 0; i--) if (resp_valid[i]) g = i;
        got_id.push_back(g);
        got_ck.push_back(resp_checksum);
        last_resp_ck  = resp_checksum;
        last_resp_cyc = cyc;
        last_id       = exp_id[0];
        void'(exp_id.pop_front());
        void'(exp_ck.pop_front());
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_resp_valid"}, resp_valid, '0);
    chk({tag, "_resp_checksum"}, resp_checksum, 32'd0);
    chk({tag, "_resp_error"}, resp_error, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant_id"}, grant_id, '0);
    chk({tag, "_core_valid"}, core_data_valid, 1'b0);
    chk({tag, "_core_data"}, core_data, 8'd0);
    chk({tag, "_core_last"}, core_last_data, 1'b0);
  endtask

  task automatic apply_reset(input int n, input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bq[i].delete(); lq[i].delete(); ck_pend[i].delete();
      cnt_pend[i] = 0; mid[i] = 1'b0;
    end
    exp_id.delete(); exp_ck.delete();
    acc = '0; model_ptr = 0;
    repeat (n) step();
    check_zero(tag);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (exp_id.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, exp_id.size(), 0);
    exp_id.delete(); exp_ck.delete();
    repeat (3) step();
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_grant_id"}, grant_id, last_id);
  endtask

  initial begin
    logic [7:0] m[$];
    int l0, nm;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    core_lat = 1; zl = 1'b0; spur = 1'b0; gap_pct = 0;
    cyc = 0; last_resp_cyc = 0; last_id = 0; last_resp_ck = 32'd0; model_ptr = 0; acc = '0;

    apply_reset(3, "reset");

    // "Hello" from requester 0
    got_id.delete(); got_ck.delete();
    m = {8'd72, 8'd101, 8'd108, 8'd108, 8'd111};
    l0 = cyc;
    add_msg(0, m); commit();
    drain(200, "hello");
    chk("hello_ck", last_resp_ck, 32'h058c01f5);
    chk("hello_owner", got_id[0], 0);
    chk("hello_latency", last_resp_cyc - l0, 9);

    // "a" on req0 and "abc" on req1 together after reset
    apply_reset(1, "reset2");
    got_id.delete(); got_ck.delete();
    m = {8'd97}; add_msg(0, m);
    m = {8'd97, 8'd98, 8'd99}; add_msg(1, m);
    commit();
    drain(200, "two");
    chk("two_first", got_id[0], 0);
    chk("two_second", got_id[1], 1);
    chk("two_ck_a", got_ck[0], 32'h00620062);
    chk("two_ck_abc", got_ck[1], 32'h024d0127);

    // Fairness: every requester always has a 1-byte message pending
    apply_reset(1, "reset3");
    got_id.delete(); got_ck.delete();
    for (int r = 0; r < NREQ; r++) begin
      add_rand_msg(r, 1); add_rand_msg(r, 1);
    end
    commit();
    drain(300, "fair");
    for (int k = 0; k < 5; k++) chk("fair_order", got_id[k], k % NREQ);

    // Long gappy stream on req2 with req1 pending, plus a stray core pulse mid-stream
    got_id.delete(); got_ck.delete();
    gap_pct = 50; core_lat = 3;
    add_rand_msg(2, 24); commit();
    repeat (3) step();
    spur = 1'b1; step(); spur = 1'b0;
    add_rand_msg(1, 5); commit();
    drain(600, "gaps");
    chk("gaps_first", got_id[0], 2);
    chk("gaps_second", got_id[1], 1);

    // Stray core pulse while idle must be ignored
    spur = 1'b1; step(); spur = 1'b0;
    repeat (3) step();
    chk("spur_idle_busy", busy, 1'b0);

    // Reset in the middle of req1's stream
    gap_pct = 0; core_lat = 1;
    add_rand_msg(1, 12); commit();
    repeat (4) step();
    chk("mid_busy", busy, 1'b1);
    apply_reset(1, "midrst");
    got_id.delete(); got_ck.delete();
    add_rand_msg(3, 2); add_rand_msg(0, 2); commit();
    drain(200, "postrst");
    chk("postrst_first", got_id[0], 0);
    chk("postrst_second", got_id[1], 3);

    // Core answering on the last-byte cycle
    zl = 1'b1; gap_pct = 30;
    for (int r = 0; r < NREQ; r++) add_rand_msg(r, $urandom_range(1, 6));
    commit();
    drain(500, "zerolat");
    zl = 1'b0;

    // Random batches
    for (int b = 0; b < 25; b++) begin
      core_lat = $urandom_range(1, 4);
      gap_pct  = $urandom_range(0, 60);
      nm = 0;
      for (int r = 0; r < NREQ; r++) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          add_rand_msg(r, $urandom_range(1, 8));
          nm++;
        end
      end
      if (nm == 0) add_rand_msg($urandom_range(0, NREQ - 1), $urandom_range(1, 8));
      commit();
      drain(3000, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
